// File: rtl/parking_occupancy_counter.sv
// Lot occupancy counter with saturating count, sticky error flags, and a sequential BCD converter for free spaces.
// Optional peak register is enabled with `define OCC_PEAK_EN; otherwise peak_count is tied to zero.
module parking_occupancy_counter #(
  parameter int unsigned CAPACITY  = 99,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned NEAR_FULL = 90
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
  input  logic             err_clr,
  input  logic             peak_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             near_full,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic [7:0]       free_bcd,
  output logic             bcd_valid,
  output logic [CNT_W-1:0] peak_count
);

  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] NEAR_C = CNT_W'(NEAR_FULL);
  localparam int unsigned      SC_W   = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(CNT_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_state_e;

  logic             inc_q, dec_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, near_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             changed;

  bcd_state_e       state_q;
  logic             pending_q;
  logic [SC_W-1:0]  sc_q;
  logic [CNT_W-1:0] bin_q;
  logic [7:0]       acc_q, adj;
  logic [7:0]       free_bcd_q;
  logic             bcd_valid_q;
  logic             unused_adj_msb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      inc_q <= increment;
      dec_q <= decrement;
    end
  end

  // Error set takes priority over err_clr in the same cycle
  always_comb begin
    count_d = count_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    unf_d   = err_clr ? 1'b0 : unf_q;
    if (inc_q && !dec_q) begin
      if (count_q == CAP_C) ovf_d = 1'b1;
      else                  count_d = count_q + 1'b1;
    end else if (dec_q && !inc_q) begin
      if (count_q == '0) unf_d = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  assign changed = (count_d != count_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      near_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CAP_C);
      empty_q <= (count_d == '0);
      near_q  <= (count_d >= NEAR_C);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    adj = acc_q;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
  end

  assign unused_adj_msb = adj[7];

  // LOAD samples count_q one cycle after the IDLE->LOAD edge, so a change on that
  // edge is already captured and must not re-arm pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b1;
      sc_q        <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      free_bcd_q  <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q) state_q <= LOAD;
        end
        LOAD: begin
          bin_q   <= CAP_C - count_q;
          acc_q   <= '0;
          sc_q    <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          acc_q <= {adj[6:0], bin_q[CNT_W-1]};
          bin_q <= bin_q << 1;
          sc_q  <= sc_q + 1'b1;
          if (sc_q == SC_LAST) state_q <= DONE;
        end
        DONE: begin
          free_bcd_q <= acc_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (state_q == IDLE && pending_q) pending_q <= 1'b0;
      else if (changed)                 pending_q <= 1'b1;

      if (changed)              bcd_valid_q <= 1'b0;
      else if (state_q == DONE) bcd_valid_q <= ~pending_q;
    end
  end

`ifdef OCC_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr || (count_q > peak_q)) peak_d = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_count      = '0;
`endif

  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign near_full     = near_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign free_bcd      = free_bcd_q;
  assign bcd_valid     = bcd_valid_q;

endmodule
